multi_debouncer: RTL and testbench

Parametrised multi-channel push-button conditioner and the successor to the single-channel rising-edge debouncer. Each channel is an independent instance with:
- a two-flop input synchroniser;
- a lockout state machine that debounces both press and release edges;
- a saturating hold counter that reports a long press.

It sits between the board button pins and the timer control logic. It provides one-cycle event pulses (press, release, long press) plus a clean debounced level per channel.

---
 rtl/multi_debouncer.sv | 128 ++++++++++++
 tb/tb_multi_debouncer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer: multi-channel push-button conditioner.
// Each channel synchronises its raw pin with two flops. A lockout FSM then
// debounces both the press and the release edge, and a saturating hold
// counter reports a long press. All outputs are registered.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_in         [CHANNELS] raw asynchronous button pins
//   btn_level      [CHANNELS] debounced pressed state (1 = pressed)
//   press_pulse    [CHANNELS] one-cycle pulse on accepted press
//   release_pulse  [CHANNELS] one-cycle pulse on accepted release
//   long_pulse     [CHANNELS] one-cycle pulse when a press is held long enough

module md_lane #(
  parameter int LOCKOUT_CYCLES = 1048576,
  parameter int LONG_CYCLES    = 25000000,
  parameter int ACTIVE_LEVEL   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  localparam int CW = $clog2(LONG_CYCLES);
  localparam logic ACT = 1'(ACTIVE_LEVEL);
  // The lockout exits on the increment that brings cnt to LOCKOUT_CYCLES-1.
  // The channel therefore listens again exactly LOCKOUT_CYCLES edges after
  // the accepted edge.
  localparam logic [CW-1:0] LOCK_END  = CW'(LOCKOUT_CYCLES - 2);
  localparam logic [CW-1:0] LONG_FIRE = CW'(LONG_CYCLES - 2);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOCK_PRESS, HELD, LOCK_REL} state_t;

  state_t        state;
  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          pressed;

  assign pressed = (sync2 == ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Sync flops reset to the idle level, so reset itself produces no event.
      sync1  <= ~ACT;
      sync2  <= ~ACT;
      state  <= IDLE;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      long_p <= 1'b0;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      press  <= 1'b0;
      rel    <= 1'b0;
      long_p <= 1'b0;
      case (state)
        IDLE: if (pressed) begin
          press <= 1'b1;
          level <= 1'b1;
          cnt   <= '0;
          state <= LOCK_PRESS;
        end
        LOCK_PRESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LOCK_END) state <= HELD;
        end
        HELD: begin
          // Release wins over a long press landing in the same cycle.
          if (!pressed) begin
            rel   <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
            state <= LOCK_REL;
          end else if (cnt != LONG_SAT) begin
            // cnt keeps counting from the press through the lockout.
            // The long pulse is therefore timed from the press pulse.
            // Saturation gives at most one long pulse per press.
            cnt <= cnt + 1'b1;
            if (cnt == LONG_FIRE) long_p <= 1'b1;
          end
        end
        LOCK_REL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LOCK_END) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module multi_debouncer #(
  parameter int CHANNELS       = 4,
  parameter int LOCKOUT_CYCLES = 1048576,
  parameter int LONG_CYCLES    = 25000000,
  parameter int ACTIVE_LEVEL   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    md_lane #(
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LEVEL  (ACTIVE_LEVEL)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (btn_in[g]),
      .level (btn_level[g]),
      .press (press_pulse[g]),
      .rel   (release_pulse[g]),
      .long_p(long_pulse[g])
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer. It runs two instances side by side, one
// active-high and one active-low. Each is compared every cycle against an
// event-timing model. The model uses these rules:
//   - the FSM sees the pin level sampled two edges earlier;
//   - an edge is accepted once LOCK cycles have passed since the last
//     accepted edge;
//   - a long pulse fires LONG-1 edges after the press while still pressed.
module tb_multi_debouncer;
  localparam int LOCK = 4;
  localparam int LONG = 10;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pin_hi, pin_lo;
  logic [1:0] lvl_hi, prs_hi, rel_hi, lng_hi;
  logic [1:0] lvl_lo, prs_lo, rel_lo, lng_lo;

  always #5 clk = ~clk;

  multi_debouncer #(.CHANNELS(2), .LOCKOUT_CYCLES(LOCK), .LONG_CYCLES(LONG), .ACTIVE_LEVEL(1)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .btn_in(pin_hi), .btn_level(lvl_hi),
    .press_pulse(prs_hi), .release_pulse(rel_hi), .long_pulse(lng_hi));

  multi_debouncer #(.CHANNELS(2), .LOCKOUT_CYCLES(LOCK), .LONG_CYCLES(LONG), .ACTIVE_LEVEL(0)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .btn_in(pin_lo), .btn_level(lvl_lo),
    .press_pulse(prs_lo), .release_pulse(rel_lo), .long_pulse(lng_lo));

  int errs = 0;
  int checks = 0;

  // Reference model state, indexed [instance][channel].
  bit         hist [2][2][HMAX];
  int         t;
  bit         mlvl [2][2];
  int         last_evt [2][2];
  int         press_t [2][2];
  logic [1:0] e_lvl [2], e_prs [2], e_rel [2], e_lng [2];

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 2; i++) begin
      e_lvl[i] = '0; e_prs[i] = '0; e_rel[i] = '0; e_lng[i] = '0;
      for (int c = 0; c < 2; c++) begin
        mlvl[i][c] = 1'b0;
        last_evt[i][c] = -100000;
        press_t[i][c] = -100000;
      end
    end
  endtask

  task automatic model_step();
    bit seen;
    logic [1:0] p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t++;
    if (t >= HMAX) $fatal(1, "FAIL model history overflow t=%0d", t);
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? pin_hi : pin_lo;
      e_prs[i] = '0; e_rel[i] = '0; e_lng[i] = '0;
      for (int c = 0; c < 2; c++) begin
        hist[i][c][t] = (p[c] == ((i == 0) ? 1'b1 : 1'b0));
        seen = (t >= 3) ? hist[i][c][t-2] : 1'b0;
        if (t >= last_evt[i][c] + LOCK && seen != mlvl[i][c]) begin
          if (seen) begin
            e_prs[i][c] = 1'b1;
            press_t[i][c] = t;
          end else begin
            e_rel[i][c] = 1'b1;
          end
          mlvl[i][c] = seen;
          last_evt[i][c] = t;
        end else if (mlvl[i][c] && t == press_t[i][c] + LONG - 1) begin
          e_lng[i][c] = 1'b1;
        end
        e_lvl[i][c] = mlvl[i][c];
      end
    end
  endtask

  task automatic check_all();
    chk("level_hi", lvl_hi, e_lvl[0]);
    chk("press_hi", prs_hi, e_prs[0]);
    chk("release_hi", rel_hi, e_rel[0]);
    chk("long_hi", lng_hi, e_lng[0]);
    chk("level_lo", lvl_lo, e_lvl[1]);
    chk("press_lo", prs_lo, e_prs[1]);
    chk("release_lo", rel_lo, e_rel[1]);
    chk("long_lo", lng_lo, e_lng[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int n, input logic [1:0] hi, input logic [1:0] lo);
    pin_hi = hi;
    pin_lo = lo;
    repeat (n) cycle();
  endtask

  // Asserts reset between edges. The outputs must clear with no clock edge.
  task automatic reset_mid(input int n);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  int unsigned hc [2][2];

  initial begin
    rst_n  = 1'b0;
    pin_hi = 2'b00;
    pin_lo = 2'b11;
    model_reset();
    #1 check_all();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Clean long press on hi ch0, then release.
    hold(30, 2'b01, 2'b11);
    hold(10, 2'b00, 2'b11);
    // Bouncy press settling to held.
    hold(1, 2'b01, 2'b11); hold(1, 2'b00, 2'b11);
    hold(1, 2'b01, 2'b11); hold(1, 2'b00, 2'b11);
    hold(12, 2'b01, 2'b11);
    hold(10, 2'b00, 2'b11);
    // Short press.
    hold(6, 2'b01, 2'b11);
    hold(10, 2'b00, 2'b11);
    // Re-press inside the release lockout.
    hold(8, 2'b01, 2'b11);
    hold(3, 2'b00, 2'b11);
    hold(12, 2'b01, 2'b11);
    hold(10, 2'b00, 2'b11);
    // Active-low pair pressed together, then ch1 released alone.
    hold(6, 2'b00, 2'b00);
    hold(12, 2'b00, 2'b10);
    hold(10, 2'b00, 2'b11);
    // Reset while held; the pin stays pressed through and after reset.
    hold(15, 2'b01, 2'b11);
    reset_mid(3);
    hold(12, 2'b01, 2'b11);
    hold(10, 2'b00, 2'b11);

    // Random hold lengths per pin: short runs act as bounces, long runs
    // reach the long-press threshold.
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) hc[i][c] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (hc[0][c] == 0) begin
          pin_hi[c] = ~pin_hi[c];
          hc[0][c] = $urandom_range(1, ($urandom_range(0, 1) != 0) ? 3 : 16);
        end
        if (hc[1][c] == 0) begin
          pin_lo[c] = ~pin_lo[c];
          hc[1][c] = $urandom_range(1, ($urandom_range(0, 1) != 0) ? 3 : 16);
        end
        hc[0][c]--;
        hc[1][c]--;
      end
      cycle();
      if (n == 1000) reset_mid(2);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
